// File: rtl/cpu_pkg.sv
// Shared types and default widths for the 8-bit CPU fetch path.
// The return stack in fetch_ctrl is compiled in only when FETCH_RAS_EN is defined.
package cpu_pkg;

   localparam int PC_W_DEF      = 8;
   localparam int INSTR_W_DEF   = 8;
   localparam int RAS_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry,
// and a pop from an empty stack is refused. Both cases set the sticky err flag.
module ret_stack #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty,
   output logic         err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr;          // next free slot; when full this is also the oldest
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic [CNT_W-1:0] count;

   assign ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
   assign ptr_dec = (ptr == '0) ? LAST : ptr - 1'b1;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign top     = mem[ptr_dec];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (push) begin
         ptr <= ptr_inc;
         if (full) begin
            err <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
      end else if (pop) begin
         if (empty) begin
            err <= 1'b1;
         end else begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads imem at pc, bumps pc, holds the instruction for decode
// and applies halt/ret/call/jump on accept. Define FETCH_RAS_EN to build in the return stack.
//
// state    | meaning
// ST_FETCH | issue imem read at pc_in
// ST_WAIT  | read outstanding; on data, latch instr and write pc+1
// ST_HOLD  | instr offered to decode; on accept apply redirect
// ST_HALT  | stopped until reset
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int INSTR_W   = INSTR_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc_in,
   output logic               pc_write,
   output logic [PC_W-1:0]    next_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   input  logic               instr_ready,
   input  logic               jump_valid,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               call_valid,
   input  logic               ret_valid,
   input  logic               halt,
   output logic               halted,
   output logic               stack_err
);

   fetch_state_t state;

   // Reset gates the combinational strobes so a late imem_valid during reset is discarded.
   assign imem_req  = (state == ST_FETCH) && !reset;
   assign imem_addr = imem_req ? pc_in : '0;

`ifdef FETCH_RAS_EN
   logic            stk_push;
   logic            stk_pop;
   logic [PC_W-1:0] stk_top;
   logic            stk_empty;
   logic            stk_full_unused;
   logic            stk_err;

   ret_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_in),
      .top       (stk_top),
      .full      (stk_full_unused),
      .empty     (stk_empty),
      .err       (stk_err)
   );

   assign stack_err = stk_err;
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_ret;

   assign unused_ret = ret_valid;
   assign stack_err  = 1'b0;
`endif

   always_comb begin
      pc_write = 1'b0;
      next_pc  = '0;
`ifdef FETCH_RAS_EN
      stk_push = 1'b0;
      stk_pop  = 1'b0;
`endif
      if (!reset) begin
         case (state)
            ST_WAIT: begin
               if (imem_valid) begin
                  pc_write = 1'b1;
                  next_pc  = pc_in + 1'b1;
               end
            end
            ST_HOLD: begin
               if (instr_ready && !halt) begin
`ifdef FETCH_RAS_EN
                  if (ret_valid) begin
                     pc_write = 1'b1;
                     next_pc  = stk_empty ? '0 : stk_top;
                     stk_pop  = 1'b1;
                  end else if (call_valid) begin
                     // pc_in has already been bumped past the call, so it is the return address
                     pc_write = 1'b1;
                     next_pc  = jump_target;
                     stk_push = 1'b1;
                  end else if (jump_valid) begin
                     pc_write = 1'b1;
                     next_pc  = jump_target;
                  end
`else
                  if (call_valid || jump_valid) begin
                     pc_write = 1'b1;
                     next_pc  = jump_target;
                  end
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_FETCH;
         instr       <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: state <= ST_WAIT;
            ST_WAIT: begin
               if (imem_valid) begin
                  instr       <= imem_data;
                  instr_valid <= 1'b1;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (halt) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised self-checking bench for fetch_ctrl; the bench models the pc register and decode.
// Build with FETCH_RAS_EN defined to exercise the return stack as well.
module tb_fetch_ctrl;

   localparam int RAS_DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pc_in;
   logic       pc_write;
   logic [7:0] next_pc;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_valid;
   logic [7:0] imem_data;
   logic       instr_valid;
   logic [7:0] instr;
   logic       instr_ready;
   logic       jump_valid;
   logic [7:0] jump_target;
   logic       call_valid;
   logic       ret_valid;
   logic       halt;
   logic       halted;
   logic       stack_err;

   fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .pc_in       (pc_in),
      .pc_write    (pc_write),
      .next_pc     (next_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_data   (imem_data),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .call_valid  (call_valid),
      .ret_valid   (ret_valid),
      .halt        (halt),
      .halted      (halted),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   // reference model: architectural pc, latched instruction, flags and return addresses
   logic [7:0] pc_m;
   logic [7:0] instr_m;
   bit         valid_m;
   bit         halted_m;
   bit         err_m;
   logic [7:0] ras[$];

   bit         e_req;
   bit         e_wr;
   logic [7:0] e_addr;
   logic [7:0] e_next;

   logic [7:0] obs_addr, obs_next, obs_instr;
   logic       obs_wr;
   logic [7:0] f_addr, f_inc, f_acc_next, f_acc_instr;
   logic       f_acc_wr;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_comb();
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", 32'(imem_addr), 32'(e_addr));
      chk("pc_write", 32'(pc_write), 32'(e_wr));
      if (e_wr) chk("next_pc", 32'(next_pc), 32'(e_next));
   endtask

   task automatic compare();
      compare_comb();
      chk("instr_valid", 32'(instr_valid), 32'(valid_m));
      chk("instr", 32'(instr), 32'(instr_m));
      chk("halted", 32'(halted), 32'(halted_m));
      chk("stack_err", 32'(stack_err), 32'(err_m));
   endtask

   task automatic idle_inputs();
      imem_valid  = 1'b0;
      imem_data   = 8'($urandom);
      instr_ready = 1'b0;
      jump_valid  = 1'b0;
      call_valid  = 1'b0;
      ret_valid   = 1'b0;
      halt        = 1'b0;
      jump_target = 8'($urandom);
   endtask

   // inputs are applied at the falling edge, outputs checked 1 time unit later
   task automatic tick();
      pc_in = pc_m;
      #1;
      compare();
      obs_addr  = imem_addr;
      obs_next  = next_pc;
      obs_wr    = pc_write;
      obs_instr = instr;
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [7:0] pc_start);
      reset       = 1'b1;
      imem_valid  = 1'b1;
      imem_data   = 8'($urandom);
      instr_ready = 1'($urandom);
      jump_valid  = 1'($urandom);
      call_valid  = 1'($urandom);
      ret_valid   = 1'($urandom);
      halt        = 1'b0;
      e_req = 1'b0;
      e_wr  = 1'b0;
      pc_in = pc_m;
      #1;
      compare_comb();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      pc_m     = pc_start;
      instr_m  = 8'h00;
      valid_m  = 1'b0;
      halted_m = 1'b0;
      err_m    = 1'b0;
      ras.delete();
   endtask

   task automatic fetch_one(input int lat, input int stall, input logic [7:0] d,
                            input bit hlt, input bit rt, input bit cl, input bit jp,
                            input logic [7:0] tgt);
      bit err_nxt;
      idle_inputs();
      e_req  = 1'b1;
      e_addr = pc_m;
      e_wr   = 1'b0;
      tick();
      f_addr = obs_addr;
      e_req  = 1'b0;
      for (int i = 1; i < lat; i++) tick();
      imem_valid = 1'b1;
      imem_data  = d;
      e_wr       = 1'b1;
      e_next     = pc_m + 8'd1;
      tick();
      f_inc      = obs_next;
      imem_valid = 1'b0;
      imem_data  = 8'($urandom);
      pc_m       = e_next;
      instr_m    = d;
      valid_m    = 1'b1;
      e_wr       = 1'b0;
      for (int i = 0; i < stall; i++) begin
         instr_ready = 1'b0;
         halt        = 1'($urandom);
         ret_valid   = 1'($urandom);
         call_valid  = 1'($urandom);
         jump_valid  = 1'($urandom);
         jump_target = 8'($urandom);
         tick();
      end
      instr_ready = 1'b1;
      halt        = hlt;
      ret_valid   = rt;
      call_valid  = cl;
      jump_valid  = jp;
      jump_target = tgt;
      err_nxt     = err_m;
      e_wr        = 1'b0;
      e_next      = 8'h00;
      if (!hlt) begin
`ifdef FETCH_RAS_EN
         if (rt) begin
            e_wr = 1'b1;
            if (ras.size() == 0) begin
               e_next  = 8'h00;
               err_nxt = 1'b1;
            end else begin
               e_next = ras.pop_back();
            end
         end else if (cl) begin
            e_wr   = 1'b1;
            e_next = tgt;
            if (ras.size() == RAS_DEPTH) begin
               void'(ras.pop_front());
               err_nxt = 1'b1;
            end
            ras.push_back(pc_m);
         end else if (jp) begin
            e_wr   = 1'b1;
            e_next = tgt;
         end
`else
         if (cl || jp) begin
            e_wr   = 1'b1;
            e_next = tgt;
         end
`endif
      end
      tick();
      f_acc_wr    = obs_wr;
      f_acc_next  = obs_next;
      f_acc_instr = obs_instr;
      valid_m     = 1'b0;
      if (e_wr) pc_m = e_next;
      if (hlt) halted_m = 1'b1;
      err_m = err_nxt;
      e_wr  = 1'b0;
      idle_inputs();
   endtask

   task automatic halt_cycles(input int n);
      e_req = 1'b0;
      e_wr  = 1'b0;
      for (int i = 0; i < n; i++) begin
         imem_valid  = 1'($urandom);
         imem_data   = 8'($urandom);
         instr_ready = 1'($urandom);
         jump_valid  = 1'($urandom);
         call_valid  = 1'($urandom);
         ret_valid   = 1'($urandom);
         halt        = 1'($urandom);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pc_m = 8'h00;
      idle_inputs();
      do_reset(8'h00);

      // first fetch after reset
      fetch_one(1, 0, 8'hA5, 0, 0, 0, 0, 8'h00);
      chk("lit_first_addr", 32'(f_addr), 32'h00);
      chk("lit_first_next_pc", 32'(f_inc), 32'h01);
      chk("lit_first_instr", 32'(f_acc_instr), 32'hA5);

      // decode stall
      fetch_one(2, 5, 8'h3C, 0, 0, 0, 0, 8'h00);
      chk("lit_stall_instr", 32'(f_acc_instr), 32'h3C);

      // pc wrap
      pc_m = 8'hFF;
      fetch_one(1, 0, 8'h11, 0, 0, 0, 0, 8'h00);
      chk("lit_wrap_next_pc", 32'(f_inc), 32'h00);

      // jump, then the following fetch address
      fetch_one(1, 1, 8'h22, 0, 0, 0, 1, 8'h40);
      chk("lit_jump_write", 32'(f_acc_wr), 32'h1);
      chk("lit_jump_next_pc", 32'(f_acc_next), 32'h40);
      fetch_one(3, 0, 8'h33, 0, 0, 0, 0, 8'h00);
      chk("lit_jump_fetch_addr", 32'(f_addr), 32'h40);

`ifdef FETCH_RAS_EN
      pc_m = 8'h10;
      fetch_one(1, 0, 8'h44, 0, 0, 1, 0, 8'h80);
      chk("lit_call_next_pc", 32'(f_acc_next), 32'h80);
      fetch_one(1, 0, 8'h55, 0, 1, 0, 0, 8'h00);
      chk("lit_ret_next_pc", 32'(f_acc_next), 32'h11);
      for (int i = 0; i < 5; i++) fetch_one(1, 0, 8'(i), 0, 0, 1, 0, 8'(8'h20 + i));
      chk("lit_five_calls_err", 32'(stack_err), 32'h1);
      do_reset(8'h30);
      chk("lit_err_after_reset", 32'(stack_err), 32'h0);
      fetch_one(1, 0, 8'h66, 0, 1, 0, 0, 8'h00);
      chk("lit_empty_ret_next_pc", 32'(f_acc_next), 32'h00);
      chk("lit_empty_ret_err", 32'(stack_err), 32'h1);
      do_reset(8'h00);
`endif

      // randomised traffic
      for (int n = 0; n < 250; n++) begin
         fetch_one(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 8'($urandom),
                   0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0), 8'($urandom));
      end

      // halt wins over a simultaneous jump
      fetch_one(1, 2, 8'h77, 1, 0, 0, 1, 8'h40);
      chk("lit_halt_no_write", 32'(f_acc_wr), 32'h0);
      halt_cycles(6);
      chk("lit_halted", 32'(halted), 32'h1);

      // reset while a read is outstanding, with data arriving in the reset cycle
      do_reset(8'h50);
      fetch_one(1, 0, 8'h99, 0, 0, 0, 0, 8'h00);
      idle_inputs();
      e_req  = 1'b1;
      e_addr = pc_m;
      e_wr   = 1'b0;
      tick();
      reset      = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 8'hEE;
      e_req      = 1'b0;
      pc_in      = pc_m;
      #1;
      compare_comb();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      instr_m  = 8'h00;
      valid_m  = 1'b0;
      halted_m = 1'b0;
      err_m    = 1'b0;
      ras.delete();
      imem_valid = 1'b1;
      imem_data  = 8'hEE;
      e_req      = 1'b1;
      e_addr     = pc_m;
      tick();
      chk("lit_rst_wait_instr", 32'(obs_instr), 32'h00);
      e_req = 1'b0;
      e_wr  = 1'b0;
      idle_inputs();
      tick();
      chk("lit_rst_wait_no_hold", 32'(instr_valid), 32'h0);
      imem_valid = 1'b1;
      imem_data  = 8'h5A;
      e_wr       = 1'b1;
      e_next     = pc_m + 8'd1;
      tick();
      imem_valid = 1'b0;
      pc_m       = e_next;
      instr_m    = 8'h5A;
      valid_m    = 1'b1;
      e_wr       = 1'b0;
      instr_ready = 1'b1;
      tick();
      chk("lit_rst_wait_recover", 32'(obs_instr), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 8-bit CPU. It owns the write side of the `pc` register: it issues instruction-memory reads at the current PC and advances the PC by one on each fetch. It holds each fetched instruction until decode accepts it, applies jump/call/return redirects, and halts on request. It sits between `pc`, instruction memory and the decode stage.

## Interface
- `PC_W`, 8: PC and address width.
- `INSTR_W`, 8: instruction width.
- `RAS_DEPTH`, 4: return-stack entries; used only when the return stack is compiled in.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `pc_in`  in  PC_W  current `pc_out` of the `pc` block.
- `pc_write`  out  1  write enable to `pc`.
- `next_pc`  out  PC_W  value written to `pc`.
- `imem_req`  out  1  read request, one-cycle pulse.
- `imem_addr`  out  PC_W  read address.
- `imem_valid`  in  1  read data valid; arrives ≥1 cycle after `imem_req`.
- `imem_data`  in  INSTR_W  read data.
- `instr_valid`  out  1  held instruction available to decode.
- `instr`  out  INSTR_W  held instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `jump_valid`  in  1  redirect to `jump_target`; sampled only on accept.
- `jump_target`  in  PC_W  redirect address.
- `call_valid`  in  1  call: jump plus push of return address; sampled only on accept.
- `ret_valid`  in  1  return: pop return address; sampled only on accept.
- `halt`  in  1  stop fetching; sampled only on accept.
- `halted`  out  1  in HALT state.
- `stack_err`  out  1  sticky return-stack over/underflow flag.

## Operation
- States: FETCH, WAIT, HOLD, HALT.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc_in`.
  - Next state is WAIT, unconditionally.
- WAIT:
  - Without `imem_valid`: stay in WAIT with no outputs asserted.
  - On `imem_valid`: register `imem_data` into `instr`, assert `pc_write`=1 with `next_pc`=`pc_in`+1 (mod 2^PC_W, so 255→0), then go to HOLD.
- HOLD:
  - `instr_valid`=1 and `instr` is stable.
  - Without `instr_ready`: stay in HOLD with no PC write.
  - On `instr_ready`, the accept, evaluate redirects in this priority order:
    - halt → HALT, no `pc_write`.
    - ret → `pc_write`, `next_pc`=top of stack, pop.
    - call → `pc_write`, `next_pc`=`jump_target`, push `pc_in` (already incremented).
    - jump → `pc_write`, `next_pc`=`jump_target`.
    - none → no write.
  - After any accept except halt, go to FETCH.
- HALT: all request/write outputs are 0 and `halted`=1. Only reset exits this state.
- Reset values:
  - State FETCH.
  - All outputs 0, including `instr` and `stack_err`.
  - Return stack empty.
  - Reset mid-WAIT discards any later `imem_valid`.

## Timing
- Minimum fetch-to-accept time is 3 cycles (FETCH, WAIT, HOLD) with 1-cycle memory and immediate `instr_ready`.
- A redirect write on accept lands in `pc` at the next edge, so the following FETCH uses the new PC.
- `pc_write` and `next_pc` are combinational from state and inputs. `instr`, `halted` and `stack_err` are registered.
- `imem_req` is never asserted in WAIT, HOLD or HALT, so at most one read is outstanding.

## Configuration
- `FETCH_RAS_EN` defined:
  - A `RAS_DEPTH`-entry return stack is present.
  - Push when full overwrites the oldest entry and sets `stack_err`.
  - Pop when empty writes `next_pc`=0 and sets `stack_err`.
- `FETCH_RAS_EN` undefined:
  - `call_valid` behaves as `jump_valid`.
  - `ret_valid` is ignored, so no write occurs.
  - `stack_err` is tied to 0 and no stack storage exists.

## Structure
- `cpu_pkg` holds:
  - the state enum (FETCH/WAIT/HOLD/HALT);
  - `PC_W` and `INSTR_W` defaults;
  - `RAS_DEPTH`.
- Sub-module `ret_stack`: circular push/pop buffer with full/empty/err outputs. It is instantiated only under `FETCH_RAS_EN`.

## Test plan
- Reset with `pc_in`=0, memory returns 0xA5 after 1 cycle, `instr_ready`=1 → `imem_addr`=0, `pc_write` with `next_pc`=1, `instr`=0xA5.
- Stall: `instr_ready` held 0 for 5 cycles → `instr_valid` stays 1, `instr` is unchanged, no `imem_req` and no `pc_write`.
- Wrap: `pc_in`=255, fetch completes → `next_pc`=0.
- Jump on accept, `jump_target`=0x40 → `pc_write` with `next_pc`=0x40, and the next `imem_addr`=0x40. Raising `halt` on the same accept instead → `halted`=1, no write, no further `imem_req`.
- `FETCH_RAS_EN`:
  - Call at `pc_in`=0x11 to 0x80, then ret → `next_pc`=0x11.
  - Five calls → `stack_err`=1.
  - Ret with an empty stack → `next_pc`=0 and `stack_err`=1.
- Reset asserted in WAIT while `imem_valid` arrives → state FETCH, `instr`=0, no `pc_write`.
